// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_pkg
//  Description : Shared types and constants for the memory_com port arbiter:
//                FSM state encoding, grant encoding, default fetch size code,
//                default timeout length and the timeout poison word.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

    typedef enum logic {
        FETCH = 1'b0,
        DATA  = 1'b1
    } grant_t;

    localparam logic [2:0]  FETCH_SIZELOAD_DEFAULT = 3'b010;
    localparam logic [23:0] TIMEOUT_CYCLES_DEFAULT = 24'd2_000_000;
    localparam logic [31:0] TIMEOUT_POISON         = 32'hDEAD_BEEF;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/mem_port_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb2
//  Description : Two-way round-robin pick between the fetch and data ports.
//                Holds last_grant; on contention the port that did not win
//                last time is picked. last_grant only moves when the caller
//                commits the grant through 'update'.
//  Ports       : clk, reset      - clock, synchronous active-high reset
//                req_fetch       - fetch port requesting
//                req_data        - data port requesting
//                update          - commit current pick into last_grant
//                gnt_valid       - at least one request is present
//                gnt_data        - 1 = data port picked, 0 = fetch port
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic req_fetch,
    input  logic req_data,
    input  logic update,
    output logic gnt_valid,
    output logic gnt_data
);

    grant_t last_grant_q;
    grant_t last_grant_d;
    grant_t pick;

    always_comb begin
        gnt_valid = req_fetch | req_data;
        if (req_fetch && req_data) begin
            pick = (last_grant_q == FETCH) ? DATA : FETCH;
        end else if (req_data) begin
            pick = DATA;
        end else begin
            pick = FETCH;
        end
        gnt_data     = (pick == DATA);
        last_grant_d = last_grant_q;
        if (update && gnt_valid) begin
            last_grant_d = pick;
        end
    end

    // Reset to FETCH so the data port wins the very first contention.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= FETCH;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares memory_com between the CPU fetch port and the data
//                load/store port. Latches one request, holds memory_com's
//                level enable until mem_done, returns read data with a
//                one-cycle ack, then waits for mem_done to fall before the
//                next grant.
//  Optional    : ARB_TIMEOUT_EN - WAIT-state timeout with err/poison return.
//  Ports       : clk, reset                    - clock, sync active-high reset
//                if_req/if_addr                - fetch request in
//                if_rdata/if_ack/if_err        - fetch response out
//                d_req/d_we/d_addr/d_wdata/
//                d_size_load/d_mem_write       - data request in
//                d_rdata/d_ack/d_err           - data response out
//                write_enable/read_enable/
//                writeData/address/SizeLoad/
//                MemWrite                      - to memory_com (registered)
//                mem_done/readData             - from memory_com
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter logic [2:0]  FETCH_SIZELOAD = FETCH_SIZELOAD_DEFAULT,
    parameter logic [23:0] TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    output logic        if_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [2:0]  d_size_load,
    input  logic [1:0]  d_mem_write,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        d_err,
    output logic        write_enable,
    output logic        read_enable,
    input  logic        mem_done,
    output logic [31:0] writeData,
    input  logic [31:0] readData,
    output logic [31:0] address,
    output logic [2:0]  SizeLoad,
    output logic [1:0]  MemWrite
);

    arb_state_t  state_q,        state_d;
    grant_t      grant_q,        grant_d;
    logic        write_enable_q, write_enable_d;
    logic        read_enable_q,  read_enable_d;
    logic [31:0] address_q,      address_d;
    logic [31:0] write_data_q,   write_data_d;
    logic [2:0]  size_load_q,    size_load_d;
    logic [1:0]  mem_write_q,    mem_write_d;
    logic [31:0] if_rdata_q,     if_rdata_d;
    logic [31:0] d_rdata_q,      d_rdata_d;
    logic        if_ack_q,       if_ack_d;
    logic        d_ack_q,        d_ack_d;

    logic        arb_update;
    logic        gnt_valid;
    logic        gnt_data;

`ifdef ARB_TIMEOUT_EN
    localparam logic [23:0] TIMEOUT_LAST = TIMEOUT_CYCLES - 24'd1;
    logic [23:0] timeout_cnt_q, timeout_cnt_d;
    logic        if_err_q,      if_err_d;
    logic        d_err_q,       d_err_d;
`endif

    rr_arb2 u_rr_arb2 (
        .clk       (clk),
        .reset     (reset),
        .req_fetch (if_req),
        .req_data  (d_req),
        .update    (arb_update),
        .gnt_valid (gnt_valid),
        .gnt_data  (gnt_data)
    );

    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        write_enable_d = write_enable_q;
        read_enable_d  = read_enable_q;
        address_d      = address_q;
        write_data_d   = write_data_q;
        size_load_d    = size_load_q;
        mem_write_d    = mem_write_q;
        if_rdata_d     = if_rdata_q;
        d_rdata_d      = d_rdata_q;
        if_ack_d       = 1'b0;
        d_ack_d        = 1'b0;
        arb_update     = 1'b0;
`ifdef ARB_TIMEOUT_EN
        if_err_d       = 1'b0;
        d_err_d        = 1'b0;
        // Zero outside WAIT so the first WAIT cycle always sees 0.
        timeout_cnt_d  = (state_q == WAIT) ? timeout_cnt_q + 24'd1 : 24'd0;
`endif

        case (state_q)
            IDLE: begin
                // A done still high from a previous transaction blocks grants.
                if (gnt_valid && !mem_done) begin
                    arb_update = 1'b1;
                    state_d    = WAIT;
                    if (gnt_data) begin
                        grant_d        = DATA;
                        address_d      = d_addr;
                        write_data_d   = d_wdata;
                        size_load_d    = d_size_load;
                        mem_write_d    = d_mem_write;
                        write_enable_d = d_we;
                        read_enable_d  = ~d_we;
                    end else begin
                        grant_d        = FETCH;
                        address_d      = if_addr;
                        write_data_d   = 32'd0;
                        size_load_d    = FETCH_SIZELOAD;
                        mem_write_d    = 2'b00;
                        write_enable_d = 1'b0;
                        read_enable_d  = 1'b1;
                    end
                end
            end

            WAIT: begin
                if (mem_done) begin
                    write_enable_d = 1'b0;
                    read_enable_d  = 1'b0;
                    state_d        = RELEASE;
                    if (grant_q == FETCH) begin
                        if_rdata_d = readData;
                        if_ack_d   = 1'b1;
                    end else begin
                        // write_enable_q is still the latched direction here.
                        if (!write_enable_q) begin
                            d_rdata_d = readData;
                        end
                        d_ack_d = 1'b1;
                    end
                end
`ifdef ARB_TIMEOUT_EN
                else if (timeout_cnt_q == TIMEOUT_LAST) begin
                    write_enable_d = 1'b0;
                    read_enable_d  = 1'b0;
                    // No done was seen, so there is nothing to release.
                    state_d        = IDLE;
                    if (grant_q == FETCH) begin
                        if_rdata_d = TIMEOUT_POISON;
                        if_ack_d   = 1'b1;
                        if_err_d   = 1'b1;
                    end else begin
                        d_rdata_d  = TIMEOUT_POISON;
                        d_ack_d    = 1'b1;
                        d_err_d    = 1'b1;
                    end
                end
`endif
            end

            RELEASE: begin
                if (!mem_done) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            grant_q        <= FETCH;
            write_enable_q <= 1'b0;
            read_enable_q  <= 1'b0;
            address_q      <= 32'd0;
            write_data_q   <= 32'd0;
            size_load_q    <= 3'd0;
            mem_write_q    <= 2'd0;
            if_rdata_q     <= 32'd0;
            d_rdata_q      <= 32'd0;
            if_ack_q       <= 1'b0;
            d_ack_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            grant_q        <= grant_d;
            write_enable_q <= write_enable_d;
            read_enable_q  <= read_enable_d;
            address_q      <= address_d;
            write_data_q   <= write_data_d;
            size_load_q    <= size_load_d;
            mem_write_q    <= mem_write_d;
            if_rdata_q     <= if_rdata_d;
            d_rdata_q      <= d_rdata_d;
            if_ack_q       <= if_ack_d;
            d_ack_q        <= d_ack_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            timeout_cnt_q <= 24'd0;
            if_err_q      <= 1'b0;
            d_err_q       <= 1'b0;
        end else begin
            timeout_cnt_q <= timeout_cnt_d;
            if_err_q      <= if_err_d;
            d_err_q       <= d_err_d;
        end
    end

    assign if_err = if_err_q;
    assign d_err  = d_err_q;
`else
    assign if_err = 1'b0;
    assign d_err  = 1'b0;
`endif

    assign write_enable = write_enable_q;
    assign read_enable  = read_enable_q;
    assign address      = address_q;
    assign writeData    = write_data_q;
    assign SizeLoad     = size_load_q;
    assign MemWrite     = mem_write_q;
    assign if_rdata     = if_rdata_q;
    assign d_rdata      = d_rdata_q;
    assign if_ack       = if_ack_q;
    assign d_ack        = d_ack_q;

endmodule : mem_port_arbiter
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single UART-backed memory communication block (memory_com) between the CPU instruction-fetch port and the data load/store port. It latches one request and drives memory_com's level-held enable handshake until mem_done. It then returns read data and a one-cycle ack to the granted requester. It sits between the CPU core and memory_com; neither CPU port talks to memory_com directly.

Parameters:
FETCH_SIZELOAD, 3'b010, SizeLoad code driven for fetches (full-word load)
TIMEOUT_CYCLES, 24'd2_000_000, WAIT-state cycles before abort (used only with ARB_TIMEOUT_EN)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
if_req  in  1  fetch request, level, held until if_ack
if_addr  in  32  fetch address
if_rdata  out  32  fetch data, valid in if_ack cycle
if_ack  out  1  one-cycle fetch completion pulse
if_err  out  1  fetch aborted by timeout, qualifies if_ack
d_req  in  1  data request, level, held until d_ack
d_we  in  1  1 = store, 0 = load
d_addr  in  32  data address
d_wdata  in  32  store data
d_size_load  in  3  load size/sign code, passed through
d_mem_write  in  2  store size code, passed through
d_rdata  out  32  load data, valid in d_ack cycle
d_ack  out  1  one-cycle data completion pulse
d_err  out  1  data access aborted by timeout, qualifies d_ack
write_enable  out  1  to memory_com, level
read_enable  out  1  to memory_com, level
mem_done  in  1  from memory_com
writeData  out  32  to memory_com
readData  in  32  from memory_com
address  out  32  to memory_com
SizeLoad  out  3  to memory_com
MemWrite  out  2  to memory_com

Behaviour:
- Single clock clk; reset is synchronous and active-high.
- Reset values:
  - All outputs are 0; state is IDLE.
  - last_grant = FETCH, so data wins the first contention.
- FSM states: IDLE, WAIT, RELEASE.
- IDLE: on an edge with any req high, grant and latch the granted port's address, data, size and direction into registers. Go to WAIT. write_enable or read_enable is high from the next cycle.
- Arbitration:
  - Only one req high: grant it.
  - Both high: grant the port that is not last_grant (round-robin). Update last_grant on each grant.
- Fetch grant:
  - read_enable = 1.
  - SizeLoad = FETCH_SIZELOAD, MemWrite = 2'b00, writeData = 0.
- Data grant:
  - d_we = 1: write_enable = 1. d_we = 0: read_enable = 1.
  - SizeLoad and MemWrite come from the latched d_size_load and d_mem_write.
- Outputs to memory_com are registered and stable for the whole transaction. Requester input changes after grant are ignored.
- WAIT: hold the enable until mem_done is sampled high at edge M. At M:
  - Capture readData into the granted port's rdata register.
  - Clear the enables.
  - Pulse the granted port's ack during cycle M+1.
  - Go to RELEASE.
- RELEASE: stay until mem_done is sampled low, then go to IDLE. No new grant is made while mem_done is high. This prevents a stale done from completing the next transaction.
- Minimum per-transaction overhead: grant +1 cycle, completion +1 cycle, release ≥1 cycle.
- rdata registers hold their value until the next completion on that port. Stores leave d_rdata unchanged.
- A req still high in the cycle after its ack is a new request.
- A requester dropping req before ack is a protocol violation. The transaction still completes and acks.
- mem_done high while in IDLE: ignored. No grant is made until it falls.
- Reset mid-transaction: enables drop on the next edge, FSM returns to IDLE, no ack is issued.
- if_err and d_err are always 0 without the optional feature.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A 24-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES-1 with mem_done low, the next edge clears the enables.
  - The granted port gets ack together with err = 1; its rdata is loaded with 32'hDEAD_BEEF.
  - FSM goes straight to IDLE.
  - mem_done and timeout on the same edge: mem_done wins.
- Undefined: no counter is built, err outputs are tied 0, and WAIT waits indefinitely.

Decomposition:
- Package mem_arb_pkg: state enum (IDLE/WAIT/RELEASE), grant enum (FETCH/DATA), FETCH_SIZELOAD default, timeout poison constant 32'hDEAD_BEEF.
- One natural sub-module: rr_arb2, a 2-way round-robin pick holding last_grant.
- The FSM and datapath latches stay in the top.

Test Plan:
- Fetch only: if_req=1, if_addr=32'h0000_0010; memory_com model raises mem_done 50 cycles after read_enable with readData=32'hA5A5_0001.
  Required: read_enable high 50 cycles, address=32'h10, SizeLoad=FETCH_SIZELOAD; if_ack 1 cycle, if_rdata=32'hA5A5_0001.
- Store: d_req=1, d_we=1, d_addr=32'h3, d_wdata=32'h1, d_mem_write=2'b10.
  Required: write_enable high, writeData=32'h1, MemWrite=2'b10; d_ack pulse; d_rdata unchanged.
- Contention: both req high from reset for 4 transactions.
  Required: grant order DATA, FETCH, DATA, FETCH; exactly one enable high at any time.
- Sticky done: model holds mem_done high 5 cycles after completion while if_req stays high.
  Required: no new enable until 1 cycle after mem_done falls.
- Reset mid-WAIT: assert reset 10 cycles into a load.
  Required: enables 0 on the next edge, no d_ack; a subsequent load completes normally.
- With ARB_TIMEOUT_EN, TIMEOUT_CYCLES=100, model never raises mem_done.
  Required: d_ack with d_err=1 and d_rdata=32'hDEAD_BEEF exactly 100 cycles after entering WAIT.
